// File: rtl/direccion_serpiente_fifo.sv
// Snake direction controller: queues button directions, applies one per tick.
// Ports: clk, rst (async high); cmd_valid/cmd in; accion, step, paused,
// q_full, drop out. Define SNAKE_REVERSE_EN to allow reversing commands.
module direccion_serpiente_fifo #(
    parameter int TICK_CYCLES = 50000000,
    parameter int QUEUE_DEPTH = 2,
    parameter int START_DIR   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic [2:0] accion,
    output logic       step,
    output logic       paused,
    output logic       q_full,
    output logic       drop
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] P_LAST  = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(QUEUE_DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [2:0]    D_START = 3'(START_DIR);

    typedef enum logic [1:0] {INICIO, MOVER, PAUSA} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [2:0]    r_q [QUEUE_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_cnt;
    logic [2:0]    r_dir;
    logic [2:0]    r_accion;
    logic          r_step;
    logic          r_paused;
    logic          r_qfull;
    logic          r_drop;

    logic [PW-1:0] w_tail_last;
    logic [2:0]    w_ref;
    logic          w_is_move;
    logic          w_is_pause;
    logic          w_is_bad;
    logic          w_tick;
    logic          w_do_pause;
    logic          w_do_resume;
    logic          w_advance;
    logic          w_pop;
    logic [2:0]    w_new_dir;
    logic          w_same;
    logic          w_opp;
    logic          w_full;
    logic          w_push;
    logic          w_reject;
    logic [CW-1:0] w_count_nx;
    logic [2:0]    w_dir_nx;
    logic [2:0]    w_accion_nx;
    logic          w_step_nx;

    // Newest queued direction is the reference for no-op/reverse checks.
    assign w_tail_last = (r_tail == '0) ? P_LAST : r_tail - 1'b1;
    assign w_ref       = (r_count != '0) ? r_q[w_tail_last] : r_dir;

    assign w_is_move   = cmd_valid && (cmd >= 3'd1) && (cmd <= 3'd4);
    assign w_is_pause  = cmd_valid && (cmd == 3'd5);
    assign w_is_bad    = cmd_valid && (cmd[2:1] == 2'b11);

    assign w_tick      = (r_state != PAUSA) && (r_cnt == T_LAST);
    assign w_do_pause  = w_is_pause && (r_state == MOVER);
    assign w_do_resume = w_is_pause && (r_state == PAUSA);
    // A pause request beats a coinciding tick.
    assign w_advance   = w_tick && !w_do_pause;
    assign w_pop       = w_advance && (r_count != '0);
    assign w_new_dir   = w_pop ? r_q[r_head] : r_dir;

    assign w_same = (w_ref == cmd);
`ifdef SNAKE_REVERSE_EN
    assign w_opp  = 1'b0;
`else
    assign w_opp  = ((w_ref == 3'd1) && (cmd == 3'd2)) ||
                    ((w_ref == 3'd2) && (cmd == 3'd1)) ||
                    ((w_ref == 3'd3) && (cmd == 3'd4)) ||
                    ((w_ref == 3'd4) && (cmd == 3'd3));
`endif
    // A pop in the same cycle frees a slot for the incoming push.
    assign w_full   = (r_count == C_FULL) && !w_pop;
    assign w_push   = w_is_move && (r_state != PAUSA) &&
                      !w_same && !w_opp && !w_full;
    assign w_reject = w_is_bad || (w_is_move && !w_push);

    assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_state_nx  = r_state;
        w_dir_nx    = r_dir;
        w_accion_nx = r_accion;
        w_step_nx   = 1'b0;
        if (w_do_pause) begin
            w_state_nx  = PAUSA;
            w_accion_nx = 3'd0;
        end else if (w_do_resume) begin
            w_state_nx  = MOVER;
            w_accion_nx = r_dir;
        end else if (w_advance) begin
            w_dir_nx = w_new_dir;
            if (w_new_dir != 3'd0) begin
                w_state_nx  = MOVER;
                w_accion_nx = w_new_dir;
                w_step_nx   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= (D_START == 3'd0) ? INICIO : MOVER;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir    <= D_START;
            r_accion <= D_START;
            r_step   <= 1'b0;
            r_paused <= 1'b0;
            r_qfull  <= 1'b0;
            r_drop   <= 1'b0;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_cnt    <= '0;
        end else begin
            r_dir    <= w_dir_nx;
            r_accion <= w_accion_nx;
            r_step   <= w_step_nx;
            r_paused <= (w_state_nx == PAUSA);
            r_qfull  <= (w_count_nx == C_FULL);
            r_drop   <= w_reject;
            r_count  <= w_count_nx;
            if (w_pop) begin
                r_head <= (r_head == P_LAST) ? '0 : r_head + 1'b1;
            end
            if (w_push) begin
                r_tail <= (r_tail == P_LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_do_resume) begin
                r_cnt <= '0;
            end else if (r_state != PAUSA) begin
                r_cnt <= (r_cnt == T_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q[i] <= 3'd0;
            end
        end else if (w_push) begin
            r_q[r_tail] <= cmd;
        end
    end

    assign accion = r_accion;
    assign step   = r_step;
    assign paused = r_paused;
    assign q_full = r_qfull;
    assign drop   = r_drop;
endmodule
